// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-stage load/store unit. Takes the ALU result as the effective byte
//   address and RD2 as store data. It drives a data-memory port that allows one
//   outstanding request (req/ack). It returns the sign- or zero-extended load
//   result to writeback and holds the pipeline stall while a transaction is in
//   flight.
//
//   Build option: MEM_TIMEOUT_EN
//     Defined:   an ack timeout of TIMEOUT_CYCLES aborts the request and pulses
//                bus_err.
//     Undefined: BUSY waits for ack forever and bus_err is tied low.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   start                 execute stage presents a memory operation
//   MemRead, MemWrite     load / store (store wins if both are high)
//   funct3                000 B, 001 H, 010 W, 100 BU, 101 HU
//   ALU_o                 effective byte address
//   RD2                   store data
//   stall                 pipeline hold
//   load_data             extended load result (holds until the next load)
//   load_valid            one-cycle pulse qualifying load_data
//   misaligned            one-cycle alignment-fault pulse
//   bus_err               one-cycle ack-timeout pulse
//   mem_req, mem_we       request (held until ack) and write enable
//   mem_addr              word-aligned address
//   mem_wdata, mem_be     lane-replicated store data and byte enables
//   mem_ack, mem_rdata    one-cycle response pulse and read word
//   state_dbg             current FSM state (IDLE=0, BUSY=1, DONE=2)
//
// Handshake: mem_req rises the cycle after acceptance. The address, byte
//   enables, write data and write enable stay stable until mem_ack is sampled
//   high. A cycle with mem_ack high and mem_req high completes the transfer.
//   mem_ack outside BUSY is ignored.
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALU_o,
    input  logic [DATA_WIDTH-1:0] RD2,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]            sz;
    logic                  accept, misalign_now, issue, timeout_hit, ack_done;
    logic [3:0]            be_d;
    logic [DATA_WIDTH-1:0] wdata_d, ext_d;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic                  we_q;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;

    assign sz           = funct3[1:0];
    assign accept       = (state_q == IDLE) && start && (MemRead || MemWrite);
    // Halfwords need bit 0 clear. Words (and the unused size 11) need both
    // low bits clear.
    assign misalign_now = ((sz == 2'b01) && ALU_o[0]) || (sz[1] && (ALU_o[1:0] != 2'b00));
    assign issue        = accept && !misalign_now;
    assign ack_done     = (state_q == BUSY) && mem_ack;

    assign stall     = issue || (state_q == BUSY);
    assign mem_req   = (state_q == BUSY);
    assign mem_we    = (state_q == BUSY) && we_q;
    assign state_dbg = state_q;

    // Store lane steering. Loads always read the full word.
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = RD2;
        if (MemWrite) begin
            case (sz)
                2'b00: begin
                    be_d    = 4'b0001 << ALU_o[1:0];
                    wdata_d = {4{RD2[7:0]}};
                end
                2'b01: begin
                    be_d    = ALU_o[1] ? 4'b1100 : 4'b0011;
                    wdata_d = {2{RD2[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = RD2;
                end
            endcase
        end
    end

    // Lane selection uses the offset captured at acceptance, not the live
    // ALU_o. Upstream has moved on by the time ack arrives.
    assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        ext_d = mem_rdata;
        case (f3_q[1:0])
            2'b00:   ext_d = {{(DATA_WIDTH-8){~f3_q[2] & byte_sel[7]}}, byte_sel};
            2'b01:   ext_d = {{(DATA_WIDTH-16){~f3_q[2] & half_sel[15]}}, half_sel};
            default: ext_d = mem_rdata;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tcnt_q;

    // Fires on the BUSY cycle whose increment would bring the count to
    // TIMEOUT_CYCLES. An ack in that same cycle takes precedence.
    assign timeout_hit = (state_q == BUSY) && !mem_ack &&
                         (tcnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
        end else if (issue) begin
            tcnt_q <= '0;
        end else if ((state_q == BUSY) && !mem_ack) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = BUSY;
            BUSY: begin
                if (mem_ack)          state_d = DONE;
                else if (timeout_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            off_q      <= '0;
            load_data  <= '0;
            load_valid <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            load_valid <= ack_done && !we_q;
            misaligned <= accept && misalign_now;
            bus_err    <= timeout_hit;
            if (issue) begin
                mem_addr  <= {ALU_o[DATA_WIDTH-1:2], 2'b00};
                mem_wdata <= wdata_d;
                mem_be    <= be_d;
                we_q      <= MemWrite;
                f3_q      <= funct3;
                off_q     <= ALU_o[1:0];
            end
            if (ack_done && !we_q) begin
                load_data <= ext_d;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit. It uses hand-computed expected values.
//   Completed loads are checked against a queue of expected load results.
//   Pulse outputs are counted by a monitor that samples on the falling edge.
//   Inputs change 1 time unit after the rising edge.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU_o, RD2;
    logic        stall, load_valid, misaligned, bus_err;
    logic [31:0] load_data;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    int lv_cnt = 0;
    int mis_cnt = 0;
    int berr_cnt = 0;
    int req_rises = 0;
    logic req_prev = 1'b0;
    logic [31:0] exp_q[$];

    mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .ALU_o      (ALU_o),
        .RD2        (RD2),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .state_dbg  (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: checks load results against the queue and counts pulses.
    always @(negedge clk) begin
        if (load_valid) begin
            lv_cnt++;
            if (exp_q.size() == 0) check("lv_spurious", 32'd1, 32'd0);
            else                   check("load_data", load_data, exp_q.pop_front());
        end
        if (misaligned) mis_cnt++;
        if (bus_err) berr_cnt++;
        if (mem_req && !req_prev) req_rises++;
        req_prev = mem_req;
    end

    task automatic idle_inputs();
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = 3'b000; ALU_o = '0; RD2 = '0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Runs one aligned operation. Start is in cycle T and ack is in cycle T+k.
    task automatic run_op(input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rd2,
                          input logic [31:0] rdata, input int k,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
        @(posedge clk); #1;
        start = 1'b1; MemRead = mr; MemWrite = mw; funct3 = f3; ALU_o = addr; RD2 = rd2;
        #1 check("stall_T", stall, 1);
        @(posedge clk); #1;
        start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; ALU_o = 32'hFFFF_FFFF; RD2 = '0;
        #1;
        check("req_T1", mem_req, 1);
        check("addr", mem_addr, exp_addr);
        check("be", {28'd0, mem_be}, {28'd0, exp_be});
        check("we", mem_we, mw);
        if (mw) check("wdata", mem_wdata, exp_wdata);
        for (int i = 1; i < k; i++) begin
            @(posedge clk); #2;
            check("req_wait", mem_req, 1);
        end
        mem_ack = 1'b1; mem_rdata = rdata;
        #1 check("stall_ack", stall, 1);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        #1;
        check("stall_done", stall, 0);
        check("req_done", mem_req, 0);
        check("lv_done", load_valid, mr && !mw);
        @(posedge clk); #2;
        check("lv_after", load_valid, 0);
    endtask

    // A misaligned load: misaligned pulses in T+1 and no request is issued.
    task automatic misalign_op(input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk); #1;
        start = 1'b1; MemRead = 1'b1; funct3 = f3; ALU_o = addr;
        #1 check("mis_stall_T", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; MemRead = 1'b0;
        #1;
        check("mis_pulse", misaligned, 1);
        check("mis_req", mem_req, 0);
        check("mis_stall", stall, 0);
        @(posedge clk); #2;
        check("mis_clear", misaligned, 0);
        check("mis_req2", mem_req, 0);
    endtask

    initial begin
        int stall_cnt;
        int rise0, lv0, berr0;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", stall, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", {28'd0, mem_be}, 0);
        check("rst_load_data", load_data, 0);
        check("rst_lv", load_valid, 0);
        check("rst_mis", misaligned, 0);
        check("rst_berr", bus_err, 0);
        check("rst_state", {30'd0, state_dbg}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Loads with sign and zero extension.
        exp_q.push_back(32'hFFFF_FF80);
        run_op(1, 0, 3'b000, 32'h103, 0, 32'h80AA_BBCC, 1, 32'h100, 4'b1111, 0);
        exp_q.push_back(32'h0000_9ABC);
        run_op(1, 0, 3'b101, 32'h202, 0, 32'h9ABC_1234, 2, 32'h200, 4'b1111, 0);
        exp_q.push_back(32'hFFFF_F00D);
        run_op(1, 0, 3'b001, 32'h200, 0, 32'h0000_F00D, 1, 32'h200, 4'b1111, 0);

        // Stores produce no load pulse, and load_data holds its value.
        run_op(0, 1, 3'b000, 32'h301, 32'h1234_5678, 0, 1, 32'h300, 4'b0010, 32'h7878_7878);
        run_op(0, 1, 3'b001, 32'h302, 32'h1234_5678, 0, 3, 32'h300, 4'b1100, 32'h5678_5678);
        check("load_hold", load_data, 32'hFFFF_F00D);
        // Store wins when both MemRead and MemWrite are high.
        run_op(1, 1, 3'b010, 32'h308, 32'hCAFE_F00D, 0, 1, 32'h308, 4'b1111, 32'hCAFE_F00D);

        // Alignment faults, then an aligned word load.
        misalign_op(3'b010, 32'h405);
        misalign_op(3'b001, 32'h201);
        check("mis_count", mis_cnt, 2);
        exp_q.push_back(32'hDEAD_BEEF);
        run_op(1, 0, 3'b010, 32'h404, 0, 32'hDEAD_BEEF, 1, 32'h404, 4'b1111, 0);

        // A start with neither MemRead nor MemWrite is ignored.
        @(posedge clk); #1 start = 1'b1; funct3 = 3'b010; ALU_o = 32'h40;
        #1 check("nop_stall", stall, 0);
        @(posedge clk); #1 start = 1'b0;
        #1 check("nop_req", mem_req, 0);

        // Ack delayed 5 cycles while start stays high: a single request.
        rise0 = req_rises;
        stall_cnt = 0;
        exp_q.push_back(32'h1122_3344);
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            start = (c < 7); MemRead = (c < 7); funct3 = 3'b010; ALU_o = 32'h500;
            mem_ack = (c == 5); mem_rdata = 32'h1122_3344;
            #1;
            if (stall) stall_cnt++;
        end
        mem_ack = 1'b0;
        check("busy_stall_cycles", stall_cnt, 6);
        check("busy_req_count", req_rises - rise0, 1);
        check("busy_no_reissue", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
        // With no ack, the request times out after 4 BUSY cycles.
        berr0 = berr_cnt;
        lv0 = lv_cnt;
        @(posedge clk); #1 start = 1'b1; MemRead = 1'b1; funct3 = 3'b010; ALU_o = 32'h800;
        @(posedge clk); #1 start = 1'b0; MemRead = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("to_berr_once", berr_cnt - berr0, 1);
        check("to_req", mem_req, 0);
        check("to_stall", stall, 0);
        check("to_no_lv", lv_cnt - lv0, 0);
        check("to_state", {30'd0, state_dbg}, 0);
`else
        berr0 = berr_cnt;
`endif

        // Reset asserted mid-BUSY drops the request at once.
        lv0 = lv_cnt;
        @(posedge clk); #1 start = 1'b1; MemRead = 1'b1; funct3 = 3'b010; ALU_o = 32'h600;
        @(posedge clk); #1 start = 1'b0; MemRead = 1'b0;
        #1 check("rb_req", mem_req, 1);
`ifndef MEM_TIMEOUT_EN
        repeat (105) @(posedge clk);
        #2;
        check("no_timeout_req", mem_req, 1);
        check("no_timeout_stall", stall, 1);
        check("no_timeout_berr", berr_cnt - berr0, 0);
`endif
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("rst_mid_req", mem_req, 0);
        check("rst_mid_stall", stall, 0);
        check("rst_mid_load_data", load_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        // An ack while idle is ignored.
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1 mem_ack = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("post_rst_req", mem_req, 0);
        check("post_rst_no_lv", lv_cnt - lv0, 0);
        check("post_rst_state", {30'd0, state_dbg}, 0);

        // A normal load completes after the reset.
        exp_q.push_back(32'h0000_00A5);
        run_op(1, 0, 3'b100, 32'h901, 0, 32'h0000_A500, 1, 32'h900, 4'b1111, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Watchdog: no directed sequence above comes near this bound.
    initial begin
        #200000;
        check("watchdog", 32'd1, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store unit for the RISC-V core. Consumes the execute stage's ALU result as the effective address and register operand 2 as store data, drives a single-outstanding req/ack data-memory port, and returns sign/zero-extended load data to writeback. It holds a pipeline stall while a transaction is in flight.

## Interface
- DATA_WIDTH, 32, datapath width; only 32 is supported.
- TIMEOUT_CYCLES, 16, ack timeout in cycles; used only with MEM_TIMEOUT_EN.
- clk  in  1  core clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  execute stage presents a memory operation this cycle.
- MemRead  in  1  the operation is a load.
- MemWrite  in  1  the operation is a store; takes priority when MemRead is also high.
- funct3  in  3  size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU apply to loads only.
- ALU_o  in  DATA_WIDTH  effective byte address.
- RD2  in  DATA_WIDTH  store data.
- stall  out  1  pipeline hold.
- load_data  out  DATA_WIDTH  extended load result.
- load_valid  out  1  one-cycle pulse qualifying load_data.
- misaligned  out  1  one-cycle pulse signalling an alignment fault.
- bus_err  out  1  one-cycle pulse signalling an ack timeout.
- mem_req  out  1  request to data memory; held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  DATA_WIDTH  word-aligned address: ALU_o with bits [1:0] forced to 0.
- mem_wdata  out  DATA_WIDTH  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory response; a one-cycle pulse.
- mem_rdata  in  DATA_WIDTH  read word; valid when mem_ack is high.

## Operation
- FSM states:
  - IDLE: waits for an accepted operation.
  - BUSY: mem_req is high.
  - DONE: one cycle in which result pulses are emitted.
- Acceptance: start is accepted in IDLE with MemRead or MemWrite high.
  - start with neither MemRead nor MemWrite is ignored.
  - start outside IDLE is ignored; upstream holds the operation because stall is high.
- Alignment check at acceptance:
  - H/HU faults if ALU_o[0] is 1.
  - W faults if ALU_o[1:0] is nonzero.
  - A faulting operation issues no request. misaligned pulses in the next cycle and the FSM stays in IDLE.
- Aligned operation: IDLE -> BUSY. Address, write enable, byte enables, write data, funct3 and ALU_o[1:0] are registered at acceptance and held stable while in BUSY.
- Store lanes:
  - SB: mem_wdata is RD2[7:0] replicated x4; mem_be = 0001 << ALU_o[1:0].
  - SH: mem_wdata is RD2[15:0] replicated x2; mem_be = 0011 when ALU_o[1] is 0, 1100 when it is 1.
  - SW: mem_wdata = RD2; mem_be = 1111.
- Loads: mem_be = 1111 and mem_we = 0. At ack, the byte or halfword is selected from mem_rdata by the registered ALU_o[1:0]; B/H are sign-extended, BU/HU are zero-extended, and W is passed through.
- BUSY with mem_ack -> DONE. For a load, load_data is registered and load_valid is high in DONE. For a store, no pulse is emitted.
- DONE -> IDLE unconditionally.
- stall is combinational: (IDLE and start is accepted and aligned) or BUSY.
- load_data holds its last value until the next load completes.

## Timing
- Reset: every output is 0 and the FSM is in IDLE. Reset takes effect immediately, mid-transaction included: mem_req drops asynchronously and any in-flight operation is discarded with no pulse.
- Acceptance in cycle T: mem_req is high from T+1.
- mem_ack in cycle T+k (k ≥ 1):
  - stall is high in cycles T through T+k and low in T+k+1.
  - load_valid is high in T+k+1.
  - A new start is accepted at T+k+2 at the earliest (in IDLE).
- Best-case load latency: 2 cycles from start to load_valid.
- mem_ack outside BUSY is ignored.
- misaligned is high in T+1; stall stays low throughout.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - If it reaches TIMEOUT_CYCLES without ack, mem_req drops, bus_err pulses for one cycle, no load_valid is emitted, and the FSM returns to IDLE.
  - An ack in the same cycle the count reaches TIMEOUT_CYCLES wins over the timeout.
- MEM_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; bus_err is tied to 0.

## Test plan
- LB at ALU_o=0x103 with ack after 1 cycle and mem_rdata=0x80AABBCC -> mem_addr=0x100, mem_be=1111, load_data=0xFFFFFF80, load_valid 2 cycles after start.
- LHU at 0x202 with mem_rdata=0x9ABC1234 -> load_data=0x00009ABC; LH at 0x200 with mem_rdata=0x0000F00D -> load_data=0xFFFFF00D.
- SB at 0x301 with RD2=0x12345678 -> mem_we=1, mem_be=0010, mem_wdata=0x78787878; SH at 0x302 -> mem_be=1100, mem_wdata=0x56785678; neither produces load_valid.
- LW at 0x405 -> misaligned pulses at T+1, mem_req stays 0, stall stays 0; a subsequent aligned LW at 0x404 completes normally.
- Ack delayed 5 cycles with start held high -> stall high for 6 cycles, exactly one request issued, and start is ignored while busy. Assert rst_n low mid-BUSY -> mem_req drops the same cycle and no pulse follows reset release.
- With MEM_TIMEOUT_EN defined and TIMEOUT_CYCLES=4 and no ack -> bus_err pulses once and the FSM returns to IDLE. With the macro undefined -> mem_req stays high past 100 cycles.
